// File: rtl/uart_pkg.sv
// Shared constants for the multi-channel UART: register offsets and status bit positions.
// Optional feature macro used by the design: UART_TX_FIFO_EN (TX FIFO per channel).
package uart_pkg;

    // Per-channel register offsets, reg_addr[1:0]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_RXDATA  = 2'd2;
    localparam logic [1:0] REG_RXCOUNT = 2'd3;

    // Status register bit positions
    localparam int ST_TX_READY  = 0;
    localparam int ST_RX_AVAIL  = 1;
    localparam int ST_RX_OVR    = 2;
    localparam int ST_TX_IDLE   = 3;

endpackage

// File: rtl/uart_chan_fifo.sv
// Synchronous FIFO used for both RX and TX channel buffering.
// Push when full and pop when empty are ignored; pop on empty with a push keeps the pushed entry.
module uart_chan_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             data_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    // A depth of 1 still gets a 1-bit pointer; the storage is rounded up to 2**AW entries
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Storage write; contents need no reset because the count defines validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/uart_serdes.sv
// 8N1 serialisers: uart_tx (valid/ready byte in, serial out) and uart_rx (serial in, one-cycle valid pulse).
// Bit period is CLK_FRE (MHz) * 1e6 / BAUD_RATE clock cycles, rounded.
module uart_tx #(
    parameter real CLK_FRE   = 25.175,
    parameter int  BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data_i,
    input  logic       tx_data_valid_i,
    output logic       tx_data_ready_o,
    output logic       tx_pin_o
);
    localparam int CYCLE = $rtoi(CLK_FRE * 1000000.0 / BAUD_RATE + 0.5);
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

    logic [1:0]  state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shf_q;
    logic        pin_q;
    logic        bit_end;

    assign bit_end         = (cnt_q == 16'(CYCLE - 1));
    assign tx_data_ready_o = (state_q == S_IDLE);
    assign tx_pin_o        = pin_q;

    // Frame sequencer: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shf_q   <= '0;
            pin_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (tx_data_valid_i) begin
                    shf_q   <= tx_data_i;
                    pin_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_START;
                end
                S_START: if (bit_end) begin
                    cnt_q   <= '0;
                    pin_q   <= shf_q[0];
                    shf_q   <= shf_q >> 1;
                    bit_q   <= '0;
                    state_q <= S_DATA;
                end else cnt_q <= cnt_q + 16'd1;
                S_DATA: if (bit_end) begin
                    cnt_q <= '0;
                    if (bit_q == 3'd7) begin
                        pin_q   <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        pin_q <= shf_q[0];
                        shf_q <= shf_q >> 1;
                        bit_q <= bit_q + 3'd1;
                    end
                end else cnt_q <= cnt_q + 16'd1;
                S_STOP: if (bit_end) begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end else cnt_q <= cnt_q + 16'd1;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

module uart_rx #(
    parameter real CLK_FRE   = 25.175,
    parameter int  BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin_i,
    output logic [7:0] rx_data_o,
    output logic       rx_data_valid_o
);
    localparam int CYCLE = $rtoi(CLK_FRE * 1000000.0 / BAUD_RATE + 0.5);
    localparam int HALF  = (CYCLE / 2 > 0) ? CYCLE / 2 : 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

    logic [1:0]  state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  data_q;
    logic        s1_q, s2_q, vld_q;
    logic        bit_end;

    assign bit_end         = (cnt_q == 16'(CYCLE - 1));
    assign rx_data_o       = data_q;
    assign rx_data_valid_o = vld_q;

    // Synchronise the pin, then sample each bit at its middle; valid only with a good stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            s1_q  <= rx_pin_i;
            s2_q  <= s1_q;
            vld_q <= 1'b0;
            case (state_q)
                S_IDLE: if (!s2_q) begin
                    cnt_q   <= '0;
                    state_q <= S_START;
                end
                S_START: if (cnt_q == 16'(HALF - 1)) begin
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    state_q <= s2_q ? S_IDLE : S_DATA;
                end else cnt_q <= cnt_q + 16'd1;
                S_DATA: if (bit_end) begin
                    cnt_q  <= '0;
                    data_q <= {s2_q, data_q[7:1]};
                    if (bit_q == 3'd7) state_q <= S_STOP;
                    else               bit_q   <= bit_q + 3'd1;
                end else cnt_q <= cnt_q + 16'd1;
                S_STOP: if (bit_end) begin
                    cnt_q   <= '0;
                    vld_q   <= s2_q;
                    state_q <= S_IDLE;
                end else cnt_q <= cnt_q + 16'd1;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_multi.sv
// Multi-channel UART register block for the 6502 bus: per-channel RX FIFO, TX buffer,
// sticky overrun and a combined RX interrupt.
// Build option UART_TX_FIFO_EN: TX FIFO of TX_DEPTH entries; otherwise one holding register.
module uart_multi
    import uart_pkg::*;
#(
    parameter real CLK_FRE   = 25.175,
    parameter int  BAUD_RATE = 115200,
    parameter int  CHANNELS  = 2,
    parameter int  RX_DEPTH  = 16,
    parameter int  TX_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_cs,
    input  logic                          R_W_n,
    input  logic [$clog2(CHANNELS)+1:0]   reg_addr,
    input  logic [7:0]                    data_i,
    output logic [7:0]                    data_o,
    input  logic [CHANNELS-1:0]           uart_rx,
    output logic [CHANNELS-1:0]           uart_tx,
    output logic                          irq
);
    localparam int CHW = $clog2(CHANNELS);
`ifdef UART_TX_FIFO_EN
    localparam int TXD = TX_DEPTH;
`else
    // Single holding register; TX_DEPTH has no effect in this build
    localparam int TXD = (TX_DEPTH > 0) ? 1 : 1;
`endif
    localparam int RXCW = $clog2(RX_DEPTH) + 1;
    localparam int TXCW = $clog2(TXD) + 1;

    // Zero-pad so the channel field exists even with a single channel
    logic [CHW+2:0]               addr_x;
    logic [CHW:0]                 ch_sel;
    logic [1:0]                   reg_sel;
    logic                         rst_n;
    logic [CHANNELS-1:0][7:0]     rdata;
    logic [CHANNELS-1:0]          rx_avail;

    assign addr_x  = {1'b0, reg_addr};
    assign ch_sel  = addr_x[CHW+2:2];
    assign reg_sel = addr_x[1:0];
    assign rst_n   = ~rst;
    assign irq     = |rx_avail;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic            sel, wr_tx, rd_st, rd_rx;
        logic [7:0]      shadow_q, rx_byte, rx_head, tx_head, status, rx_cnt8;
        logic            rx_vld, rx_full, rx_empty, ovr_q;
        logic [RXCW-1:0] rx_cnt;
        logic            tx_full, tx_empty, tx_rdy, tv_q, tv_d, tx_pop, tx_push_ok;
        logic [TXCW-1:0] tx_cnt;

        assign sel        = uart_cs && (ch_sel == (CHW+1)'(i));
        assign wr_tx      = sel && !R_W_n && (reg_sel == REG_TXDATA);
        assign rd_st      = sel &&  R_W_n && (reg_sel == REG_STATUS);
        assign rd_rx      = sel &&  R_W_n && (reg_sel == REG_RXDATA);
        assign tx_push_ok = wr_tx && !tx_full;
        assign tx_pop     = tv_q && tx_rdy;

        uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) u_rx (
            .clk(clk), .rst_n(rst_n), .rx_pin_i(uart_rx[i]),
            .rx_data_o(rx_byte), .rx_data_valid_o(rx_vld)
        );

        uart_chan_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rxf (
            .clk(clk), .rst(rst), .push_i(rx_vld), .pop_i(rd_rx), .data_i(rx_byte),
            .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
        );

        uart_chan_fifo #(.DEPTH(TXD), .W(8)) u_txf (
            .clk(clk), .rst(rst), .push_i(wr_tx), .pop_i(tx_pop), .data_i(data_i),
            .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
        );

        uart_tx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) u_tx (
            .clk(clk), .rst_n(rst_n), .tx_data_i(tx_head), .tx_data_valid_i(tv_q),
            .tx_data_ready_o(tx_rdy), .tx_pin_o(uart_tx[i])
        );

        // Valid stays up after a pop only if an entry remains behind the one handed over
        always_comb begin
            tv_d = !tx_empty;
            if (tx_pop) tv_d = (tx_cnt > TXCW'(1)) || tx_push_ok;
        end

        // Drain valid, TX shadow and sticky overrun (a new overrun wins over a clearing read)
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tv_q     <= 1'b0;
                shadow_q <= '0;
                ovr_q    <= 1'b0;
            end else begin
                tv_q <= tv_d;
                if (wr_tx) shadow_q <= data_i;
                if (rx_vld && rx_full) ovr_q <= 1'b1;
                else if (rd_st)        ovr_q <= 1'b0;
            end
        end

        // Status byte and saturated RX count
        always_comb begin
            status              = '0;
            status[ST_TX_READY] = !tx_full;
            status[ST_RX_AVAIL] = !rx_empty;
            status[ST_RX_OVR]   = ovr_q;
            status[ST_TX_IDLE]  = tx_empty && tx_rdy;
            rx_cnt8 = (32'(rx_cnt) > 32'd255) ? 8'hFF : 8'(rx_cnt);
        end

        // Per-channel read data for the current register offset
        always_comb begin
            case (reg_sel)
                REG_TXDATA: rdata[i] = shadow_q;
                REG_STATUS: rdata[i] = status;
                REG_RXDATA: rdata[i] = rx_empty ? 8'h00 : rx_head;
                default:    rdata[i] = rx_cnt8;
            endcase
        end

        assign rx_avail[i] = !rx_empty;
    end

    // Channel read mux; out-of-range channel numbers read 0
    always_comb begin
        data_o = 8'h00;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_sel == (CHW+1)'(c)) data_o = rdata[c];
        end
    end

endmodule

// File: doc/uart_multi.md
# uart_multi

Parametrised multi-channel UART peripheral for the 6502 bus: CHANNELS independent UARTs, each with an RX FIFO, an optional TX FIFO, sticky overrun status and a combined receive interrupt. It replaces the fixed two-channel, single-byte-buffered UART block. It sits on the CPU register bus behind one chip select and drives the board serial pins.

## Interface
- CLK_FRE, 25.175: clock frequency in MHz, passed to the serialisers.
- BAUD_RATE, 115200: baud rate in bit/s, same for all channels.
- CHANNELS, 2: number of UART channels, 1..8.
- RX_DEPTH, 16: RX FIFO entries per channel, power of two, 2..256.
- TX_DEPTH, 16: TX FIFO entries per channel, power of two, 2..256. Used only with UART_TX_FIFO_EN.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- uart_cs  in  1  register access strobe, high for exactly one clk cycle per CPU access.
- R_W_n  in  1  1 = read, 0 = write.
- reg_addr  in  $clog2(CHANNELS)+2  {channel, reg[1:0]}.
- data_i  in  8  write data.
- data_o  out  8  read data, combinational from reg_addr.
- uart_rx  in  CHANNELS  serial inputs, one bit per channel.
- uart_tx  out  CHANNELS  serial outputs, idle high.
- irq  out  1  high while any channel's RX FIFO is non-empty.

## Operation
Per-channel registers, selected by reg[1:0]:
- 0, TX data. A write pushes data_i. A read returns the last byte written.
- 1, status. Bit0 is tx_ready (TX FIFO not full). Bit1 is rx_avail (RX FIFO not empty). Bit2 is rx_overrun (sticky). Bit3 is tx_idle (TX FIFO empty and serialiser ready). Bits 7:4 read 0. A read clears rx_overrun.
- 2, RX data. A read returns the RX FIFO head, or 0 if empty, and pops one entry. A write has no effect.
- 3, RX count. Reads return the occupancy, saturated to 255.

RX path:
- A serialiser rx_data_valid pushes the byte.
- If the FIFO is full, the byte is dropped and rx_overrun sets. FIFO contents are unchanged.
- Push and pop in the same cycle both take effect. Count is unchanged.
- On an empty FIFO, push and pop in the same cycle: the pop is ignored and the pushed byte is retained.
- A pop on an empty FIFO does nothing.

TX path:
- A write when the FIFO is full is ignored.
- The drain logic presents the FIFO head to the serialiser with a registered tx_data_valid.
- An entry is popped on tx_data_valid && tx_data_ready. tx_data_valid deasserts the cycle after the pop unless another entry remains.
- Pointers wrap modulo depth. Occupancy is kept in a counter $clog2(DEPTH)+1 bits wide.
- Reset, including mid-frame, empties all FIFOs, clears rx_overrun and the TX data shadow, and resets the serialisers. Serialisers take rst_n = ~rst.

Reset values:
- uart_tx = all ones.
- irq = 0.
- data_o reflects the reset state: status reads 0x09 (tx_ready, tx_idle), other registers read 0.

## Timing
- A register write takes effect at the clk edge where uart_cs is high.
- Status reflects a write from the following cycle.
- TX latency: write at edge N, tx_data_valid high after edge N+1, start bit driven by the serialiser thereafter.
- RX latency: rx_data_valid at edge N, so rx_avail and irq are high after edge N.
- The read side effect (pop, overrun clear) occurs at the edge ending the uart_cs cycle. data_o is sampled by the CPU before that edge.
- Channels are fully independent. Simultaneous events on different channels all take effect.

## Configuration
UART_TX_FIFO_EN:
- Defined: each channel has a TX FIFO of TX_DEPTH entries.
- Undefined: a single holding register per channel (depth 1). tx_ready = holding register empty. A write when occupied is ignored. TX_DEPTH is unused.
- The register map is identical in both builds.

## Structure
- Package uart_pkg holds:
  - register offset constants: REG_TXDATA = 0, REG_STATUS = 1, REG_RXDATA = 2, REG_RXCOUNT = 3;
  - status bit index constants.
- Sub-module uart_chan_fifo is a parametrised synchronous FIFO with push/pop/full/empty/count, used for RX and TX. It is instantiated per channel in a generate loop, alongside the existing uart_rx and uart_tx serialisers.

## Test plan
- Reset, then read status of channel 0 -> 0x09. RX count -> 0. uart_tx all high. irq = 0.
- Write 0x55, 0xA3, 0x0F to channel 1 TX data back-to-back -> three frames on uart_tx[1] in order, 8N1 at BAUD_RATE. tx_idle returns to 1 after the last stop bit.
- Inject RX_DEPTH+1 bytes 0x00..0x10 on channel 0 -> count = RX_DEPTH, rx_overrun = 1. Reads return 0x00..0x0F, and 0x10 is lost. The status read clears overrun.
- Pop channel 0 on the same cycle rx_data_valid arrives with count = 3 -> count stays 3. The correct head is returned and no byte is lost.
- Without UART_TX_FIFO_EN, write 0x11 then immediately 0x22 -> only 0x11 is transmitted. tx_ready = 0 until the serialiser accepts 0x11.
- Assert rst mid-frame on channel 1 TX and RX -> uart_tx[1] high immediately, FIFOs empty, irq = 0. The next frame is received correctly.
